// File: rtl/ycr1_axi_burst_mem.sv
// AXI4 INCR-burst memory model: byte-addressed array, independent read and write channels.
// Latency: write response one cycle after the last W beat; first R beat RD_LAT+1 cycles after AR.
// Backpressure: one burst per channel in flight; R and B hold steady until the master accepts them.
//
// Ports: clk/rst (sync, active-high); AW/W/B write channel; AR/R read channel.
// Beats at byte addresses >= SIZE are dropped (write) or return zero (read) with SLVERR.
module ycr1_axi_burst_mem #(
  parameter int SIZE   = 65536,
  parameter int W_ID   = 4,
  parameter int W_DATA = 32,
  parameter int RD_LAT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [W_ID-1:0]     awid,
  input  logic [31:0]         awaddr,
  input  logic [7:0]          awlen,
  input  logic                wvalid,
  output logic                wready,
  input  logic [W_DATA-1:0]   wdata,
  input  logic [W_DATA/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [W_ID-1:0]     bid,
  output logic [1:0]          bresp,
  input  logic                arvalid,
  output logic                arready,
  input  logic [W_ID-1:0]     arid,
  input  logic [31:0]         araddr,
  input  logic [7:0]          arlen,
  output logic                rvalid,
  input  logic                rready,
  output logic [W_ID-1:0]     rid,
  output logic [W_DATA-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast
);

  localparam int NB    = W_DATA / 8;
  localparam int OFF   = $clog2(NB);
  localparam int DEPTH = SIZE / NB;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] BEAT_B = 32'(NB);
  localparam logic [3:0] WAIT_INIT = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;

  localparam logic [1:0] WS_IDLE = 2'd0, WS_DATA = 2'd1, WS_RESP = 2'd2;
  localparam logic [1:0] R_IDLE  = 2'd0, R_WAIT  = 2'd1, R_DATA  = 2'd2;

  // Contents are deliberately not reset so data survives rst.
  logic [W_DATA-1:0] mem_q [DEPTH];

  function automatic logic in_range(input logic [31:0] a);
    return a < 32'(SIZE);
  endfunction

  // Low address bits select a byte inside the beat and are ignored.
  function automatic logic [AW-1:0] widx(input logic [31:0] a);
    return a[OFF +: AW];
  endfunction

  // ---------------- write channel ----------------
  logic [1:0]      wstate_q, wstate_d;
  logic [W_ID-1:0] wid_q, wid_d, bid_q, bid_d;
  logic [31:0]     waddr_q, waddr_d;
  logic [7:0]      wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic            werr_q, werr_d, bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            w_at_len, w_beat_err, w_mem_en;

  assign w_at_len   = (wcnt_q == wlen_q);
  assign w_beat_err = !in_range(waddr_q);
  assign w_mem_en   = !rst && (wstate_q == WS_DATA) && wvalid && !w_beat_err;

  always_comb begin
    wstate_d = wstate_q;
    wid_d    = wid_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wcnt_d   = wcnt_q;
    werr_d   = werr_q;
    bvalid_d = bvalid_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    case (wstate_q)
      WS_IDLE: if (awvalid) begin
        wid_d    = awid;
        waddr_d  = awaddr;
        wlen_d   = awlen;
        wcnt_d   = 8'd0;
        werr_d   = 1'b0;
        wstate_d = WS_DATA;
      end
      WS_DATA: if (wvalid) begin
        // Burst closes on whichever comes first; disagreement is a protocol error.
        if (wlast || w_at_len) begin
          wstate_d = WS_RESP;
          bvalid_d = 1'b1;
          bid_d    = wid_q;
          bresp_d  = (werr_q || w_beat_err || (wlast != w_at_len)) ? 2'b10 : 2'b00;
        end else begin
          waddr_d = waddr_q + BEAT_B;
          wcnt_d  = wcnt_q + 8'd1;
          werr_d  = werr_q || w_beat_err;
        end
      end
      WS_RESP: if (bready) begin
        bvalid_d = 1'b0;
        wstate_d = WS_IDLE;
      end
      default: wstate_d = WS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_mem_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) mem_q[widx(waddr_q)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  logic [1:0]        rstate_q, rstate_d;
  logic [W_ID-1:0]   rid_q, rid_d;
  logic [31:0]       raddr_q, raddr_d, rd_addr;
  logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [3:0]        rwait_q, rwait_d;
  logic              rvalid_q, rvalid_d, rlast_q, rlast_d, rd_load;
  logic [W_DATA-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  always_comb begin
    rstate_d = rstate_q;
    rid_d    = rid_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rcnt_d   = rcnt_q;
    rwait_d  = rwait_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rd_load  = 1'b0;
    rd_addr  = raddr_q;
    case (rstate_q)
      R_IDLE: if (arvalid) begin
        rid_d    = arid;
        raddr_d  = araddr;
        rlen_d   = arlen;
        rcnt_d   = 8'd0;
        rwait_d  = WAIT_INIT;
        rstate_d = (RD_LAT == 0) ? R_DATA : R_WAIT;
      end
      R_WAIT: begin
        if (rwait_q == 4'd0) rstate_d = R_DATA;
        else                 rwait_d  = rwait_q - 4'd1;
      end
      R_DATA: begin
        if (!rvalid_q) begin
          rd_load = 1'b1;
        end else if (rready) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            rstate_d = R_IDLE;
          end else begin
            // Fetch the following beat on the accepting edge for full-rate streaming.
            rd_addr = raddr_q + BEAT_B;
            raddr_d = rd_addr;
            rcnt_d  = rcnt_q + 8'd1;
            rd_load = 1'b1;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    if (rd_load) begin
      rvalid_d = 1'b1;
      rlast_d  = (rcnt_d == rlen_q);
      if (in_range(rd_addr)) begin
        rdata_d = mem_q[widx(rd_addr)];
        rresp_d = 2'b00;
      end else begin
        rdata_d = '0;
        rresp_d = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q <= WS_IDLE;
      wid_q    <= '0;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wcnt_q   <= '0;
      werr_q   <= 1'b0;
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= 2'b00;
      rstate_q <= R_IDLE;
      rid_q    <= '0;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rcnt_q   <= '0;
      rwait_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else begin
      wstate_q <= wstate_d;
      wid_q    <= wid_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wcnt_q   <= wcnt_d;
      werr_q   <= werr_d;
      bvalid_q <= bvalid_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
      rstate_q <= rstate_d;
      rid_q    <= rid_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rcnt_q   <= rcnt_d;
      rwait_q  <= rwait_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign awready = (wstate_q == WS_IDLE);
  assign wready  = (wstate_q == WS_DATA);
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = (rstate_q == R_IDLE);
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

endmodule

// File: tb/tb_ycr1_axi_burst_mem.sv
module tb_ycr1_axi_burst_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid = 1'b0, awready;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        bvalid, bready = 1'b0;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0, arready;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic        rvalid, rready = 1'b1;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;
  beat_t sb[$];

  ycr1_axi_burst_mem #(.SIZE(4096), .W_ID(4), .W_DATA(32), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  always #5 clk = ~clk;

  function automatic void push_beat(input logic [31:0] d, input logic [1:0] resp,
                                    input logic last, input logic [3:0] id);
    beat_t e;
    e.d = d; e.resp = resp; e.last = last; e.id = id;
    sb.push_back(e);
  endfunction

  // Full write burst: nbeats data beats (wlast on the final one sent), data = base + i*step.
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input int nbeats, input logic [31:0] base, input logic [31:0] step,
                           input logic [3:0] strb, output logic [1:0] resp, output logic [3:0] rbid);
    int t;
    resp = 2'bxx; rbid = 4'bxxxx;
    @(posedge clk); #1;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len;
    t = 0; @(negedge clk);
    while (!awready && t < 20) begin @(negedge clk); t++; end
    if (!awready) begin checks++; errors++; $display("FAIL aw_timeout got awready=%b want 1", awready); end
    @(posedge clk); #1 awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1'b1; wdata = base + step * 32'(i); wstrb = strb; wlast = (i == nbeats - 1);
      t = 0; @(negedge clk);
      while (!wready && t < 20) begin @(negedge clk); t++; end
      if (!wready) begin checks++; errors++; $display("FAIL w_timeout got wready=%b want 1", wready); end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    t = 0; @(negedge clk);
    while (!bvalid && t < 20) begin @(negedge clk); t++; end
    if (!bvalid) begin checks++; errors++; $display("FAIL b_timeout got bvalid=%b want 1", bvalid); end
    resp = bresp; rbid = bid;
    @(posedge clk); #1 bready = 1'b0;
  endtask

  // Read burst; expected beats must already be queued in sb. Returns cycles from AR
  // handshake to first rvalid. stop_after >= 0 returns after that many beats are accepted.
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [3:0] rr_pat, input int stop_after, output int lat);
    int t, n, popped, idx;
    logic stall;
    logic [31:0] sd;
    logic [3:0] sid;
    logic sl;
    beat_t e;
    idx = 0; n = 0; popped = 0; stall = 1'b0; sd = '0; sid = '0; sl = 1'b0;
    @(posedge clk); #1;
    rready = rr_pat[0];
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len;
    t = 0; @(negedge clk);
    while (!arready && t < 20) begin @(negedge clk); t++; end
    if (!arready) begin checks++; errors++; $display("FAIL ar_timeout got arready=%b want 1", arready); end
    @(posedge clk); #1 arvalid = 1'b0;
    lat = 0; @(negedge clk);
    while (!rvalid && lat < 40) begin lat++; @(negedge clk); end
    while (sb.size() > 0 && n < 100 && popped != stop_after) begin
      if (stall) begin
        checks++;
        if (rvalid !== 1'b1 || rdata !== sd || rid !== sid || rlast !== sl) begin
          errors++;
          $display("FAIL r_stall got v=%b d=%h id=%h l=%b want v=1 d=%h id=%h l=%b",
                   rvalid, rdata, rid, rlast, sd, sid, sl);
        end
      end
      stall = rvalid && !rready; sd = rdata; sid = rid; sl = rlast;
      if (rvalid && rready) begin
        e = sb.pop_front(); popped++; checks++;
        if (rdata !== e.d || rresp !== e.resp || rlast !== e.last || rid !== e.id) begin
          errors++;
          $display("FAIL r_beat got d=%h resp=%b last=%b id=%h want d=%h resp=%b last=%b id=%h",
                   rdata, rresp, rlast, rid, e.d, e.resp, e.last, e.id);
        end
      end
      if (sb.size() > 0 && popped != stop_after) begin
        @(posedge clk); #1;
        idx = (idx + 1) % 4; rready = rr_pat[idx];
        @(negedge clk); n++;
      end
    end
    if (sb.size() > 0 && popped != stop_after) begin
      checks++; errors++;
      $display("FAIL r_timeout got %0d beats left want 0", sb.size());
    end
    if (stop_after < 0) begin
      @(negedge clk); checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL r_extra got rvalid=%b want 0", rvalid); end
      rready = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 11;
    if (awready !== 1'b1) begin errors++; $display("FAIL rst_awready got %b want 1", awready); end
    if (arready !== 1'b1) begin errors++; $display("FAIL rst_arready got %b want 1", arready); end
    if (wready  !== 1'b0) begin errors++; $display("FAIL rst_wready got %b want 0", wready); end
    if (bvalid  !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %b want 0", bvalid); end
    if (rvalid  !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", rvalid); end
    if (rlast   !== 1'b0) begin errors++; $display("FAIL rst_rlast got %b want 0", rlast); end
    if (bresp   !== 2'b00) begin errors++; $display("FAIL rst_bresp got %b want 00", bresp); end
    if (rresp   !== 2'b00) begin errors++; $display("FAIL rst_rresp got %b want 00", rresp); end
    if (bid     !== 4'h0) begin errors++; $display("FAIL rst_bid got %h want 0", bid); end
    if (rid     !== 4'h0) begin errors++; $display("FAIL rst_rid got %h want 0", rid); end
    if (rdata   !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", rdata); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_burst;
    logic [1:0] r; logic [3:0] b; int lat;
    axi_write(4'h3, 32'h100, 8'd3, 4, 32'h11111111, 32'h11111111, 4'hF, r, b);
    checks += 2;
    if (r !== 2'b00) begin errors++; $display("FAIL burst_bresp got %b want 00", r); end
    if (b !== 4'h3) begin errors++; $display("FAIL burst_bid got %h want 3", b); end
    for (int i = 0; i < 4; i++) push_beat(32'h11111111 * (i + 1), 2'b00, i == 3, 4'h5);
    axi_read(4'h5, 32'h100, 8'd3, 4'b1111, -1, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL burst_latency got %0d want 3", lat); end
  endtask

  task automatic test_strobe;
    logic [1:0] r; logic [3:0] b; int lat;
    axi_write(4'h1, 32'h200, 8'd0, 1, 32'h0, 32'h0, 4'hF, r, b);
    axi_write(4'h2, 32'h200, 8'd0, 1, 32'hAABBCCDD, 32'h0, 4'b0101, r, b);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL strb_bresp got %b want 00", r); end
    push_beat(32'h00BB00DD, 2'b00, 1'b1, 4'h7);
    axi_read(4'h7, 32'h202, 8'd0, 4'b1111, -1, lat);
  endtask

  task automatic test_oob;
    logic [1:0] r; logic [3:0] b; int lat;
    axi_write(4'h9, 32'hFFC, 8'd1, 2, 32'hCAFEF00D, 32'h1, 4'hF, r, b);
    checks += 2;
    if (r !== 2'b10) begin errors++; $display("FAIL oob_bresp got %b want 10", r); end
    if (b !== 4'h9) begin errors++; $display("FAIL oob_bid got %h want 9", b); end
    push_beat(32'hCAFEF00D, 2'b00, 1'b0, 4'hA);
    push_beat(32'h0, 2'b10, 1'b1, 4'hA);
    axi_read(4'hA, 32'hFFC, 8'd1, 4'b1111, -1, lat);
  endtask

  task automatic test_stall;
    int lat;
    for (int i = 0; i < 4; i++) push_beat(32'h11111111 * (i + 1), 2'b00, i == 3, 4'hC);
    axi_read(4'hC, 32'h100, 8'd3, 4'b1001, -1, lat);
  endtask

  task automatic test_early_wlast;
    logic [1:0] r; logic [3:0] b;
    axi_write(4'h6, 32'h400, 8'd3, 2, 32'h55550000, 32'h1, 4'hF, r, b);
    checks += 2;
    if (r !== 2'b10) begin errors++; $display("FAIL wlast_bresp got %b want 10", r); end
    @(negedge clk);
    if (awready !== 1'b1) begin errors++; $display("FAIL wlast_idle got awready=%b want 1", awready); end
  endtask

  task automatic test_reset_mid;
    logic [1:0] r; logic [3:0] b; int lat;
    axi_write(4'h4, 32'h300, 8'd7, 8, 32'h30000000, 32'h1, 4'hF, r, b);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL rmid_bresp got %b want 00", r); end
    for (int i = 0; i < 8; i++) push_beat(32'h30000000 + 32'(i), 2'b00, i == 7, 4'hE);
    axi_read(4'hE, 32'h300, 8'd7, 4'b1111, 2, lat);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks += 3;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL rmid_rvalid got %b want 0", rvalid); end
    if (arready !== 1'b1) begin errors++; $display("FAIL rmid_arready got %b want 1", arready); end
    if (rlast !== 1'b0) begin errors++; $display("FAIL rmid_rlast got %b want 0", rlast); end
    sb.delete();
    for (int i = 0; i < 8; i++) push_beat(32'h30000000 + 32'(i), 2'b00, i == 7, 4'h2);
    axi_read(4'h2, 32'h300, 8'd7, 4'b1111, -1, lat);
  endtask

  initial begin
    test_reset();
    test_burst();
    test_strobe();
    test_oob();
    test_stall();
    test_early_wlast();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
